// File: rtl/register_file_scoreboard.sv
// Parametrised integer register file with hardwired zero register, same-cycle
// write-to-read bypass and a per-register pending-write scoreboard. A clear
// sequencer zeroes the array after reset instead of resetting it.
module register_file_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int READ_PORTS = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  output logic                             ready,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             reserve_enable,
  input  logic [ADDR_WIDTH-1:0]            reserve_address,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_WIDTH:0]   COUNT_W = (ADDR_WIDTH+1)'(REG_COUNT);
  localparam logic [ADDR_WIDTH-1:0] FIRST   = ZERO_REG ? ADDR_WIDTH'(1) : '0;
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(REG_COUNT - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [REG_COUNT-1:0]    pending_q, pending_d;
  logic [DATA_WIDTH-1:0]   regs_q [REG_COUNT];
  logic                    clr_we;
  logic                    wr_valid;
  logic                    rsv_valid;

  // Address is architecturally writable/reservable: in range and not the zero register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < COUNT_W) && !(ZERO_REG && (a == '0));
  endfunction

  // State and sweep counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep one register per cycle, enter RUN after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = RUN;
    end
  end

  // FSM outputs.
  always_comb begin
    ready  = (state_q == RUN);
    clr_we = (state_q == CLEAR);
  end

  assign wr_valid  = ready && write_enable   && addr_ok(write_address);
  assign rsv_valid = ready && reserve_enable && addr_ok(reserve_address);

  // Array write: clear sweep or writeback; the array itself carries no reset.
  always_ff @(posedge clock) begin
    if (clr_we)        regs_q[cnt_q]         <= '0;
    else if (wr_valid) regs_q[write_address] <= write_data;
  end

  // Scoreboard update: clear on writeback, then set on reserve so a same-cycle reserve wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_valid)  pending_d[write_address]   = 1'b0;
    if (rsv_valid) pending_d[reserve_address] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;
    assign ra  = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit = BYPASS && wr_valid && (write_address == ra);

    // Combinational read with forwarding and busy indication.
    always_comb begin
      read_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      read_busy[p]                          = 1'b0;
      if (ready && addr_ok(ra)) begin
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = hit ? write_data : regs_q[ra];
        read_busy[p]                          = pending_q[ra] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        write_enable, reserve_enable;
  logic [4:0]  write_address, reserve_address;
  logic [31:0] write_data;
  logic [9:0]  read_address;
  logic [63:0] rd_b, rd_n;
  logic [1:0]  busy_b, busy_n;
  logic        ready_b, ready_n;

  int checks = 0;
  int errors = 0;

  register_file_scoreboard dut (
    .clock(clock), .reset_n(reset_n), .ready(ready_b),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_address(reserve_address),
    .read_address(read_address), .read_data(rd_b), .read_busy(busy_b)
  );

  register_file_scoreboard #(.BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .ready(ready_n),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_address(reserve_address),
    .read_address(read_address), .read_data(rd_n), .read_busy(busy_n)
  );

  always #5 clock = ~clock;

  task automatic set_ports(input logic [4:0] a0, input logic [4:0] a1);
    read_address = {a1, a0};
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0; write_address = '0; write_data = '0;
    reserve_enable = 1'b0; reserve_address = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    set_ports(5'd3, 5'd4);
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (ready_b !== 1'b0 || ready_n !== 1'b0 || rd_b !== 64'h0 || busy_b !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: ready=%b/%b data=%h busy=%b expected 0/0 0 00", ready_b, ready_n, rd_b, busy_b);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clock); #1;
      checks++;
      if (ready_b !== (k == 31) || ready_n !== (k == 31)) begin
        errors++;
        $display("FAIL sweep_ready cycle %0d: got %b/%b expected %b", k, ready_b, ready_n, (k == 31));
      end
    end
    for (int r = 0; r < 32; r++) begin
      set_ports(5'(r), 5'(31 - r));
      #1;
      checks++;
      if (rd_b !== 64'h0 || rd_n !== 64'h0 || busy_b !== 2'b00 || busy_n !== 2'b00) begin
        errors++;
        $display("FAIL cleared_read r%0d/r%0d: got %h %h busy %b %b expected all 0", r, 31 - r, rd_b, rd_n, busy_b, busy_n);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd5; write_data = 32'hDEADBEEF;
    set_ports(5'd5, 5'd1);
    #1;
    checks++;
    if (rd_b[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_fwd: got %h expected deadbeef", rd_b[31:0]);
    end
    checks++;
    if (rd_n[31:0] !== 32'h0) begin
      errors++; $display("FAIL nobypass_old: got %h expected 00000000", rd_n[31:0]);
    end
    @(negedge clock);
    idle_inputs();
    set_ports(5'd5, 5'd5);
    #1;
    checks++;
    if (rd_b !== {2{32'hDEADBEEF}} || rd_n !== {2{32'hDEADBEEF}}) begin
      errors++; $display("FAIL written_both_ports: got %h %h expected deadbeefdeadbeef", rd_b, rd_n);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd0; write_data = 32'h00001234;
    reserve_enable = 1'b1; reserve_address = 5'd0;
    set_ports(5'd0, 5'd0);
    #1;
    checks++;
    if (rd_b !== 64'h0 || rd_n !== 64'h0 || busy_b !== 2'b00) begin
      errors++; $display("FAIL zero_same_cycle: got %h %h busy %b expected 0 0 00", rd_b, rd_n, busy_b);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (rd_b !== 64'h0 || rd_n !== 64'h0 || busy_b !== 2'b00 || busy_n !== 2'b00) begin
      errors++; $display("FAIL zero_after: got %h %h busy %b %b expected 0 0 00 00", rd_b, rd_n, busy_b, busy_n);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clock);
    reserve_enable = 1'b1; reserve_address = 5'd7;
    set_ports(5'd0, 5'd7);
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (busy_b[1] !== 1'b1 || busy_n[1] !== 1'b1) begin
      errors++; $display("FAIL reserved_busy: got %b/%b expected 1/1", busy_b[1], busy_n[1]);
    end
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd7; write_data = 32'hA5A5A5A5;
    #1;
    checks++;
    if (busy_b[1] !== 1'b0 || rd_b[63:32] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL wb_fwd: busy %b data %h expected 0 a5a5a5a5", busy_b[1], rd_b[63:32]);
    end
    checks++;
    if (busy_n[1] !== 1'b1 || rd_n[63:32] !== 32'h0) begin
      errors++; $display("FAIL wb_nobypass: busy %b data %h expected 1 00000000", busy_n[1], rd_n[63:32]);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (busy_b[1] !== 1'b0 || busy_n[1] !== 1'b0 || rd_b[63:32] !== 32'hA5A5A5A5 || rd_n[63:32] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL after_wb: busy %b/%b data %h/%h expected 0/0 a5a5a5a5", busy_b[1], busy_n[1], rd_b[63:32], rd_n[63:32]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    reserve_enable = 1'b1; reserve_address = 5'd7;
    write_enable = 1'b1; write_address = 5'd7; write_data = 32'h11;
    set_ports(5'd7, 5'd7);
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h11 || busy_b !== 2'b00) begin
      errors++; $display("FAIL same_cycle_fwd: data %h busy %b expected 00000011 00", rd_b[31:0], busy_b);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h11 || rd_n[31:0] !== 32'h11 || busy_b !== 2'b11 || busy_n !== 2'b11) begin
      errors++; $display("FAIL set_wins: data %h/%h busy %b/%b expected 00000011 11", rd_b[31:0], rd_n[31:0], busy_b, busy_n);
    end
    @(negedge clock); #1;
    checks++;
    if (busy_b !== 2'b11) begin
      errors++; $display("FAIL busy_holds: got %b expected 11", busy_b);
    end
    @(negedge clock);
    write_enable = 1'b1; write_address = 5'd7; write_data = 32'h22;
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h22 || busy_b !== 2'b00 || busy_n !== 2'b00) begin
      errors++; $display("FAIL later_write: data %h busy %b/%b expected 00000022 00", rd_b[31:0], busy_b, busy_n);
    end
  endtask

  task automatic test_reset_rerun();
    @(negedge clock);
    reserve_enable = 1'b1; reserve_address = 5'd9;
    @(negedge clock);
    idle_inputs();
    set_ports(5'd5, 5'd9);
    #1;
    checks++;
    if (rd_b[31:0] !== 32'hDEADBEEF || busy_b[1] !== 1'b1) begin
      errors++; $display("FAIL pre_reset: data %h busy %b expected deadbeef 1", rd_b[31:0], busy_b[1]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (ready_b !== 1'b0 || rd_b !== 64'h0 || busy_b !== 2'b00) begin
      errors++; $display("FAIL async_drop: ready %b data %h busy %b expected 0 0 00", ready_b, rd_b, busy_b);
    end
    @(negedge clock);
    reset_n = 1'b1;
    write_enable = 1'b1; write_address = 5'd5; write_data = 32'hCAFEF00D;
    reserve_enable = 1'b1; reserve_address = 5'd5;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ready_b !== 1'b0) begin
      errors++; $display("FAIL mid_sweep_ready: got %b expected 0", ready_b);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clock); #1;
      checks++;
      if (ready_b !== (k == 31) || (k < 31 && (rd_b !== 64'h0 || busy_b !== 2'b00))) begin
        errors++;
        $display("FAIL rerun_sweep cycle %0d: ready %b data %h busy %b expected ready %b", k, ready_b, rd_b, busy_b, (k == 31));
      end
      if (k >= 30) idle_inputs();
    end
    #1;
    checks++;
    if (rd_b !== 64'h0 || busy_b !== 2'b00 || rd_n !== 64'h0 || busy_n !== 2'b00) begin
      errors++; $display("FAIL post_rerun: data %h/%h busy %b/%b expected 0 00", rd_b, rd_n, busy_b, busy_n);
    end
    set_ports(5'd7, 5'd7);
    #1;
    checks++;
    if (rd_b !== 64'h0 || busy_b !== 2'b00) begin
      errors++; $display("FAIL post_rerun_x7: data %h busy %b expected 0 00", rd_b, busy_b);
    end
  endtask

  initial begin
    set_ports(5'd0, 5'd0);
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_reset_rerun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
